descrack_result_arbiter: RTL

DESCRACK_RESULT_ARBITER -- requirements
Module: descrack_result_arbiter

---
 rtl/descrack_result_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/descrack_result_arbiter.sv
// Round-robin collector of cracked-key results from NREQ cores, serialized as 32-bit FSL words.
// Optional macro DESCRACK_RESULT_SEQ_EN appends a fourth word carrying a running sequence number.
module descrack_result_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*88-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [31:0]       fsl_data_o,
  output logic              fsl_valid_o,
  input  logic              fsl_full_i,
  output logic              busy
);

`ifdef DESCRACK_RESULT_SEQ_EN
  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;
`else
  typedef enum logic [2:0] {IDLE, W0, W1, W2} state_t;
`endif

  state_t       state;
  logic [2:0]   last_grant;
  logic [2:0]   cap_idx;
  logic [55:0]  cap_hi;
  logic         grant_found;
  logic [2:0]   grant_idx;
  logic [87:0]  grant_data;
  logic [NREQ-1:0] grant_onehot;
  logic         xfer;

`ifdef DESCRACK_RESULT_SEQ_EN
  logic [31:0]  seq_cnt;
`endif

  // Round-robin search: the requester just after the last grant has the highest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] &&
            (i == ((int'(last_grant) + off) % NREQ))) begin
          grant_found = 1'b1;
          grant_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data   = '0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_data      = req_data[i*88 +: 88];
        grant_onehot[i] = grant_found;
      end
    end
  end

  // The ack marks the cycle whose closing edge captures the data, so it must not wait a cycle.
  assign req_ack = (rst_n && (state == IDLE)) ? grant_onehot : '0;
  assign busy    = (state != IDLE);
  assign xfer    = fsl_valid_o && !fsl_full_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 3'(NREQ - 1);
      cap_idx     <= '0;
      cap_hi      <= '0;
      fsl_data_o  <= '0;
      fsl_valid_o <= 1'b0;
`ifdef DESCRACK_RESULT_SEQ_EN
      seq_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cap_hi      <= grant_data[87:32];
            cap_idx     <= grant_idx;
            last_grant  <= grant_idx;
            fsl_data_o  <= grant_data[31:0];
            fsl_valid_o <= 1'b1;
            state       <= W0;
          end
        end
        W0: begin
          if (xfer) begin
            fsl_data_o <= {5'b0, cap_idx, cap_hi[23:0]};
            state      <= W1;
          end
        end
        W1: begin
          if (xfer) begin
            fsl_data_o <= cap_hi[55:24];
            state      <= W2;
          end
        end
        W2: begin
          if (xfer) begin
`ifdef DESCRACK_RESULT_SEQ_EN
            fsl_data_o  <= seq_cnt;
            state       <= W3;
`else
            fsl_data_o  <= '0;
            fsl_valid_o <= 1'b0;
            state       <= IDLE;
`endif
          end
        end
`ifdef DESCRACK_RESULT_SEQ_EN
        W3: begin
          if (xfer) begin
            seq_cnt     <= seq_cnt + 32'd1;
            fsl_data_o  <= '0;
            fsl_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
`endif
        default: begin
          fsl_data_o  <= '0;
          fsl_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
